i2c_wb_sequencer: RTL and testbench

- Wishbone master that sequences the i2c_master_wb_top core through its byte-wide register map: PRERlo=0, PRERhi=1, CTR=2, TXR/RXR=3, CR/SR=4.
- After reset it programs the prescaler and enables the core.
- It then executes single-byte register write or read transactions to an I2C slave on request, polling SR for completion and slave ACK.
- Sits between a local requester (CPU glue or a hardwired init ROM) and the I2C core.

---
 rtl/i2c_wb_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_i2c_wb_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_sequencer
// Brief    : Wishbone master that initialises an i2c_master_wb_top core and
//            runs single-byte I2C register writes/reads on request.
//            Optional poll watchdog: define I2C_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_wb_sequencer #(
    parameter logic [15:0] PRESCALE       = 16'h000A,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       req_i,
    input  logic       req_rd_i,
    input  logic [6:0] dev_addr_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] wr_data_i,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic [7:0] rd_data_o,
    output logic [2:0] m_wb_adr_o,
    output logic [7:0] m_wb_dat_o,
    input  logic [7:0] m_wb_dat_i,
    output logic       m_wb_we_o,
    output logic       m_wb_stb_o,
    output logic       m_wb_cyc_o,
    input  logic       m_wb_ack_i
);

    localparam logic [3:0] c_INIT_PRL   = 4'd0;
    localparam logic [3:0] c_INIT_PRH   = 4'd1;
    localparam logic [3:0] c_INIT_CTR   = 4'd2;
    localparam logic [3:0] c_IDLE       = 4'd3;
    localparam logic [3:0] c_LD_TXR     = 4'd4;
    localparam logic [3:0] c_LD_CR      = 4'd5;
    localparam logic [3:0] c_POLL_SR    = 4'd6;
    localparam logic [3:0] c_CHECK      = 4'd7;
    localparam logic [3:0] c_RD_RXR     = 4'd8;
    localparam logic [3:0] c_ABORT_CR   = 4'd9;
    localparam logic [3:0] c_ABORT_POLL = 4'd10;
    localparam logic [3:0] c_FINISH     = 4'd11;

    localparam logic [2:0] c_ADR_PRERLO = 3'd0;
    localparam logic [2:0] c_ADR_PRERHI = 3'd1;
    localparam logic [2:0] c_ADR_CTR    = 3'd2;
    localparam logic [2:0] c_ADR_TXR    = 3'd3;
    localparam logic [2:0] c_ADR_CR     = 3'd4;

    logic [3:0] r_state;
    logic [1:0] r_phase;
    logic       r_rd;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic       r_sr_tip;
    logic       r_sr_nack;
    logic       r_abort;
    logic       r_init_done;
    logic       r_busy;
    logic       r_done;
    logic       r_nack;
    logic [7:0] r_rd_data;
    logic       r_cyc;
    logic [2:0] r_adr;
    logic [7:0] r_dat;
    logic       r_we;

    logic       w_ack;
    logic [7:0] w_txr;
    logic [7:0] w_cr;
    logic       w_last_phase;
    logic       w_acc_en;
    logic [2:0] w_acc_adr;
    logic [7:0] w_acc_dat;
    logic       w_acc_we;
    logic       w_tmo_hit;
    logic       w_abort_stop;

    assign w_ack = r_cyc & m_wb_ack_i;

    // Phase-indexed TXR/CR contents; read transactions add a repeated start and a final NACKed read.
    always_comb begin
        w_txr = {r_dev, 1'b0};
        w_cr  = 8'h90;
        case (r_phase)
            2'd1: begin
                w_txr = r_reg;
                w_cr  = 8'h10;
            end
            2'd2: begin
                w_txr = r_rd ? {r_dev, 1'b1} : r_wdata;
                w_cr  = r_rd ? 8'h90 : 8'h50;
            end
            2'd3: w_cr = 8'h68;
            default: ;
        endcase
    end

    assign w_last_phase = r_rd ? (r_phase == 2'd3) : (r_phase == 2'd2);

    always_comb begin
        w_acc_en  = 1'b1;
        w_acc_adr = c_ADR_CR;
        w_acc_dat = 8'h00;
        w_acc_we  = 1'b1;
        case (r_state)
            c_INIT_PRL: begin
                w_acc_adr = c_ADR_PRERLO;
                w_acc_dat = PRESCALE[7:0];
            end
            c_INIT_PRH: begin
                w_acc_adr = c_ADR_PRERHI;
                w_acc_dat = PRESCALE[15:8];
            end
            c_INIT_CTR: begin
                w_acc_adr = c_ADR_CTR;
                w_acc_dat = 8'h80;
            end
            c_LD_TXR: begin
                w_acc_adr = c_ADR_TXR;
                w_acc_dat = w_txr;
            end
            c_LD_CR:      w_acc_dat = w_cr;
            c_POLL_SR:    w_acc_we  = 1'b0;
            c_RD_RXR: begin
                w_acc_adr = c_ADR_TXR;
                w_acc_we  = 1'b0;
            end
            c_ABORT_CR:   w_acc_dat = 8'h40;
            c_ABORT_POLL: w_acc_we  = 1'b0;
            default:      w_acc_en  = 1'b0;
        endcase
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic        r_timed_out;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt   <= 16'd0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_ack && (r_state == c_LD_CR || r_state == c_ABORT_CR)) begin
                r_tmo_cnt <= 16'd0;
            end else if ((r_state == c_POLL_SR || r_state == c_CHECK ||
                          r_state == c_ABORT_POLL) && r_tmo_cnt != c_TMO_LIMIT) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (r_state == c_IDLE && req_i) begin
                r_timed_out <= 1'b0;
            end else if (r_state == c_CHECK && r_sr_tip && w_tmo_hit) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign w_tmo_hit    = (r_tmo_cnt == c_TMO_LIMIT);
    // After a watchdog abort the core is presumed hung: a single SR read closes the transaction.
    assign w_abort_stop = r_timed_out | w_tmo_hit;
`else
    localparam logic [15:0] c_unused_tmo_limit = 16'(TIMEOUT_CYCLES);

    assign w_tmo_hit    = 1'b0;
    assign w_abort_stop = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state     <= c_INIT_PRL;
            r_phase     <= 2'd0;
            r_rd        <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_sr_tip    <= 1'b0;
            r_sr_nack   <= 1'b0;
            r_abort     <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_rd_data   <= 8'd0;
            r_cyc       <= 1'b0;
            r_adr       <= 3'd0;
            r_dat       <= 8'd0;
            r_we        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Bus cycle engine: launch from an idle bus, drop the edge after ack.
            if (r_cyc) begin
                if (m_wb_ack_i) begin
                    r_cyc <= 1'b0;
                end
            end else if (w_acc_en) begin
                r_cyc <= 1'b1;
                r_adr <= w_acc_adr;
                r_dat <= w_acc_dat;
                r_we  <= w_acc_we;
            end

            case (r_state)
                c_INIT_PRL: if (w_ack) r_state <= c_INIT_PRH;
                c_INIT_PRH: if (w_ack) r_state <= c_INIT_CTR;
                c_INIT_CTR: begin
                    if (w_ack) begin
                        r_init_done <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (req_i) begin
                        r_rd    <= req_rd_i;
                        r_dev   <= dev_addr_i;
                        r_reg   <= reg_addr_i;
                        r_wdata <= wr_data_i;
                        r_phase <= 2'd0;
                        r_abort <= 1'b0;
                        r_busy  <= 1'b1;
                        r_nack  <= 1'b0;
                        r_state <= c_LD_TXR;
                    end
                end
                c_LD_TXR: if (w_ack) r_state <= c_LD_CR;
                c_LD_CR:  if (w_ack) r_state <= c_POLL_SR;
                c_POLL_SR: begin
                    if (w_ack) begin
                        r_sr_tip  <= m_wb_dat_i[1];
                        r_sr_nack <= m_wb_dat_i[7];
                        r_state   <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (r_sr_tip) begin
                        if (w_tmo_hit) begin
                            r_abort <= 1'b1;
                            r_state <= c_ABORT_CR;
                        end else begin
                            r_state <= c_POLL_SR;
                        end
                    end else if (r_phase == 2'd3) begin
                        r_state <= c_RD_RXR;
                    end else if (r_sr_nack) begin
                        r_abort <= 1'b1;
                        r_state <= c_ABORT_CR;
                    end else if (w_last_phase) begin
                        r_state <= c_FINISH;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                        r_state <= (r_rd && r_phase == 2'd2) ? c_LD_CR : c_LD_TXR;
                    end
                end
                c_RD_RXR: begin
                    if (w_ack) begin
                        r_rd_data <= m_wb_dat_i;
                        r_state   <= c_FINISH;
                    end
                end
                c_ABORT_CR: if (w_ack) r_state <= c_ABORT_POLL;
                c_ABORT_POLL: begin
                    if (w_ack && (!m_wb_dat_i[1] || w_abort_stop)) begin
                        r_state <= c_FINISH;
                    end
                end
                c_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_nack  <= r_abort;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_INIT_PRL;
            endcase
        end
    end

    assign init_done_o = r_init_done;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign nack_o      = r_nack;
    assign rd_data_o   = r_rd_data;
    assign m_wb_adr_o  = r_adr;
    assign m_wb_dat_o  = r_dat;
    assign m_wb_we_o   = r_we;
    assign m_wb_stb_o  = r_cyc;
    assign m_wb_cyc_o  = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_i2c_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_wb_sequencer
// Brief    : Self-checking bench for i2c_wb_sequencer with a behavioural
//            model of the I2C core register file and a transaction reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_wb_sequencer;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       req_rd;
    logic [6:0] dev;
    logic [7:0] regi;
    logic [7:0] wdat;
    logic       init_done;
    logic       busy;
    logic       done;
    logic       nack;
    logic [7:0] rd_data;
    logic [2:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       we;
    logic       stb;
    logic       cyc;
    logic       ack;

    always #5 clk = ~clk;

    i2c_wb_sequencer #(
        .PRESCALE       (16'h000A),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .req_i       (req),
        .req_rd_i    (req_rd),
        .dev_addr_i  (dev),
        .reg_addr_i  (regi),
        .wr_data_i   (wdat),
        .init_done_o (init_done),
        .busy_o      (busy),
        .done_o      (done),
        .nack_o      (nack),
        .rd_data_o   (rd_data),
        .m_wb_adr_o  (adr),
        .m_wb_dat_o  (dat_o),
        .m_wb_dat_i  (dat_i),
        .m_wb_we_o   (we),
        .m_wb_stb_o  (stb),
        .m_wb_cyc_o  (cyc),
        .m_wb_ack_i  (ack)
    );

    int checks = 0;
    int errors = 0;

    // Core model knobs (written by the stimulus only)
    int         ack_delay = 0;
    int         tip_polls = 0;
    int         nack_at   = -1;
    bit         tip_stuck = 1'b0;
    logic [7:0] rxr_val   = 8'h00;

    // Core model state (written by the model only)
    int          wait_cnt    = 0;
    int          tip_left    = 0;
    int          cr_writes   = 0;
    int          sr_reads    = 0;
    int          sr_at_abort = 0;
    logic        sr_nack     = 1'b0;
    logic [10:0] wlog[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            dat_i    <= 8'h00;
            wait_cnt = 0;
            tip_left = 0;
            sr_nack  = 1'b0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    ack <= 1'b1;
                    if (we) begin
                        wlog.push_back({adr, dat_o});
                        dat_i <= 8'h00;
                        if (adr == 3'd4) begin
                            cr_writes++;
                            sr_nack  = (cr_writes == nack_at);
                            tip_left = tip_polls;
                            if (dat_o == 8'h40) sr_at_abort = sr_reads;
                        end
                    end else if (adr == 3'd3) begin
                        dat_i <= rxr_val;
                    end else if (adr == 3'd4) begin
                        sr_reads++;
                        dat_i <= {sr_nack, 5'b00000, (tip_stuck || tip_left > 0), 1'b0};
                        if (tip_left > 0) tip_left--;
                    end else begin
                        dat_i <= 8'h00;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Bus protocol and done-pulse monitor
    int          done_cnt  = 0;
    int          proto_err = 0;
    logic        p_stb = 1'b0, p_ack = 1'b0, p_rst = 1'b0, p_we = 1'b0;
    logic [2:0]  p_adr = 3'd0;
    logic [7:0]  p_dat = 8'd0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && p_rst) begin
            if (p_stb && !p_ack && !(stb && adr == p_adr && dat_o == p_dat && we == p_we))
                proto_err++;
            if (p_stb && p_ack && stb) proto_err++;
        end
        if (stb !== cyc) proto_err++;
        p_stb = stb;
        p_ack = ack;
        p_rst = rst_n;
        p_adr = adr;
        p_dat = dat_o;
        p_we  = we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: register writes the core must see for one transaction.
    logic [10:0] exp_q[$];
    task automatic build_exp(input bit rd, input logic [6:0] d, input logic [7:0] r,
                             input logic [7:0] w, input int nack_ph);
        exp_q.delete();
        exp_q.push_back({3'd3, d, 1'b0});
        exp_q.push_back({3'd4, 8'h90});
        exp_q.push_back({3'd3, r});
        exp_q.push_back({3'd4, 8'h10});
        if (rd) begin
            exp_q.push_back({3'd3, d, 1'b1});
            exp_q.push_back({3'd4, 8'h90});
            exp_q.push_back({3'd4, 8'h68});
        end else begin
            exp_q.push_back({3'd3, w});
            exp_q.push_back({3'd4, 8'h50});
        end
        if (nack_ph >= 0 && nack_ph <= 2) begin
            while (exp_q.size() > 2 * nack_ph + 2) void'(exp_q.pop_back());
            exp_q.push_back({3'd4, 8'h40});
        end
    endtask

    task automatic check_log(input string tag, input int base);
        chk({tag, "_len"}, wlog.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {21'd0, wlog[base + i]}, {21'd0, exp_q[i]});
    endtask

    logic [7:0] exp_rd = 8'h00;

    task automatic do_txn(input string tag, input bit rd, input logic [6:0] d,
                          input logic [7:0] r, input logic [7:0] w, input int nack_ph,
                          input int dly, input int tips, input bit hold, input logic [7:0] rxv);
        int  base;
        int  dbase;
        int  n;
        bit  aborted;
        @(negedge clk);
        ack_delay = dly;
        tip_polls = tips;
        nack_at   = (nack_ph >= 0) ? cr_writes + nack_ph + 1 : -1;
        rxr_val   = rxv;
        base      = wlog.size();
        dbase     = done_cnt;
        req_rd    = rd;
        dev       = d;
        regi      = r;
        wdat      = w;
        req       = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
        chk({tag, "_nack_clear"}, {31'd0, nack}, 32'd0);
        if (!hold) req = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        aborted = (nack_ph >= 0 && nack_ph <= 2);
        if (rd && !aborted) exp_rd = rxv;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nack"}, {31'd0, nack}, {31'd0, aborted});
        chk({tag, "_rd_data"}, {24'd0, rd_data}, {24'd0, exp_rd});
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt - dbase, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nack_held"}, {31'd0, nack}, {31'd0, aborted});
        build_exp(rd, d, r, w, nack_ph);
        check_log(tag, base);
    endtask

    task automatic check_init(input string tag, input int base);
        logic [15:0] presc;
        int n;
        presc = 16'h000A;
        n = 0;
        while (!init_done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        exp_q.delete();
        exp_q.push_back({3'd0, presc[7:0]});
        exp_q.push_back({3'd1, presc[15:8]});
        exp_q.push_back({3'd2, 8'h80});
        check_log(tag, base);
    endtask

    initial begin
        int base;
        int dbase;
        int n;
        bit rd;
        int ph;

        rst_n  = 1'b0;
        req    = 1'b0;
        req_rd = 1'b0;
        dev    = 7'd0;
        regi   = 8'd0;
        wdat   = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_nack", {31'd0, nack}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_bus", {18'd0, cyc, stb, we, adr, dat_o}, 32'd0);

        base  = wlog.size();
        dbase = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        check_init("init", base);
        repeat (2) @(posedge clk);
        #1;
        chk("init_no_done", done_cnt - dbase, 32'd0);

        do_txn("wr_basic", 1'b0, 7'h1E, 8'h41, 8'h3C, -1, 0, 1, 1'b0, 8'h00);
        do_txn("rd_basic", 1'b1, 7'h1E, 8'h05, 8'h00, -1, 0, 2, 1'b0, 8'hA7);
        do_txn("rd_addr_nack", 1'b1, 7'h1E, 8'h05, 8'h00, 0, 1, 1, 1'b0, 8'h55);
        do_txn("wr_slow_hold", 1'b0, 7'h22, 8'h10, 8'h99, -1, 3, 2, 1'b1, 8'h00);
        do_txn("rd_p3_nack_ignored", 1'b1, 7'h50, 8'hFE, 8'h00, 3, 0, 0, 1'b0, 8'h6B);
        do_txn("wr_data_nack", 1'b0, 7'h7F, 8'h00, 8'hFF, 2, 2, 3, 1'b0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            rd = 1'($urandom_range(0, 1));
            ph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rd ? 3 : 2)) : -1;
            do_txn($sformatf("rnd%0d", i), rd, 7'($urandom), 8'($urandom), 8'($urandom), ph,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 8'($urandom));
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        @(negedge clk);
        tip_stuck = 1'b1;
        ack_delay = 0;
        nack_at   = -1;
        base      = wlog.size();
        dbase     = done_cnt;
        req_rd    = 1'b0;
        dev       = 7'h33;
        regi      = 8'h01;
        wdat      = 8'h02;
        req       = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_nack", {31'd0, nack}, 32'd1);
        chk("tmo_late_enough", {31'd0, n >= TMO}, 32'd1);
        chk("tmo_single_sr_read", sr_reads - sr_at_abort, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("tmo_done_pulses", done_cnt - dbase, 32'd1);
        build_exp(1'b0, 7'h33, 8'h01, 8'h02, 0);
        check_log("tmo", base);
        tip_stuck = 1'b0;
`endif

        // Reset while polling after the register-address phase
        @(negedge clk);
        ack_delay = 0;
        tip_polls = 30;
        nack_at   = -1;
        base      = wlog.size();
        req_rd    = 1'b0;
        dev       = 7'h1E;
        regi      = 8'h41;
        wdat      = 8'h3C;
        req       = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (wlog.size() - base < 4 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_reached_p1", {31'd0, wlog.size() - base >= 4}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_stb", {31'd0, stb}, 32'd0);
        chk("rst_mid_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_init_done", {31'd0, init_done}, 32'd0);
        exp_rd = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        base = wlog.size();
        tip_polls = 0;
        rst_n = 1'b1;
        check_init("reinit", base);
        chk("reinit_rd_data", {24'd0, rd_data}, {24'd0, exp_rd});

        do_txn("post_reset_rd", 1'b1, 7'h0C, 8'h33, 8'h00, -1, 1, 1, 1'b0, 8'h5A);

        chk("wb_protocol_violations", proto_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
